// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and helpers shared by vga_timing and draw_lines.
// draw_lines takes its P_SCREEN_W/P_SCREEN_H defaults from H_ACTIVE/V_ACTIVE.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam logic [11:0] FG_COLOUR = 12'hFFF;
    localparam logic [11:0] BG_COLOUR = 12'h000;

    function automatic int line_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Width able to hold 0..n-1, never narrower than one bit.
    function automatic int count_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_timing_mod_counter.sv
// Modulo-N counter with synchronous clear and a wrap strobe on the enabled terminal count.
module mod_counter #(
    parameter int P_W   = 4,
    parameter int P_MOD = 10
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_clr,
    input  logic           i_en,
    output logic [P_W-1:0] o_count,
    output logic           o_wrap
);

    localparam logic [P_W-1:0] LAST = P_W'(P_MOD - 1);

    logic [P_W-1:0] count_q;
    logic [P_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        o_wrap  = i_en && !i_clr && (count_q == LAST);
        if (i_clr) begin
            count_d = '0;
        end else if (i_en) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/vga_timing.sv
// VGA raster generator: undelayed counters address the screen buffer, while sync/blank
// are delayed to line up with the returned pixel so all pin outputs share one latency.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int P_X_COORD_W = 11,
    parameter int P_Y_COORD_W = 11,
    parameter int P_H_ACTIVE  = H_ACTIVE,
    parameter int P_H_FP      = H_FP,
    parameter int P_H_SYNC    = H_SYNC,
    parameter int P_H_BP      = H_BP,
    parameter int P_V_ACTIVE  = V_ACTIVE,
    parameter int P_V_FP      = V_FP,
    parameter int P_V_SYNC    = V_SYNC,
    parameter int P_V_BP      = V_BP,
    parameter int P_CLK_DIV   = 2,
    parameter int P_RD_LAT    = 1,
    parameter int P_RGB_W     = 12,
    parameter logic [P_RGB_W-1:0] P_FG_COLOUR = FG_COLOUR,
    parameter logic [P_RGB_W-1:0] P_BG_COLOUR = BG_COLOUR
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_pixel_on,
    output logic [P_X_COORD_W-1:0] o_hcounter,
    output logic [P_Y_COORD_W-1:0] o_vcounter,
    output logic                   o_hsync,
    output logic                   o_vsync,
    output logic                   o_blank,
    output logic [P_RGB_W-1:0]     o_rgb,
    output logic                   o_vblank,
    output logic                   o_frame_start
);

    localparam int H_TOT = line_total(P_H_ACTIVE, P_H_FP, P_H_SYNC, P_H_BP);
    localparam int V_TOT = line_total(P_V_ACTIVE, P_V_FP, P_V_SYNC, P_V_BP);
    localparam int PRE_W = count_width(P_CLK_DIV);

    localparam logic [P_X_COORD_W-1:0] H_ACT    = P_X_COORD_W'(P_H_ACTIVE);
    localparam logic [P_X_COORD_W-1:0] HS_START = P_X_COORD_W'(P_H_ACTIVE + P_H_FP);
    localparam logic [P_X_COORD_W-1:0] HS_END   = P_X_COORD_W'(P_H_ACTIVE + P_H_FP + P_H_SYNC);
    localparam logic [P_Y_COORD_W-1:0] V_ACT    = P_Y_COORD_W'(P_V_ACTIVE);
    localparam logic [P_Y_COORD_W-1:0] VS_START = P_Y_COORD_W'(P_V_ACTIVE + P_V_FP);
    localparam logic [P_Y_COORD_W-1:0] VS_END   = P_Y_COORD_W'(P_V_ACTIVE + P_V_FP + P_V_SYNC);

    // Pin bundle order is {hsync, vsync, blank}; idle means syncs released and blanked.
    localparam logic [2:0] PINS_IDLE = 3'b111;

    logic [PRE_W-1:0]       pre_unused;
    logic                   tick;
    logic                   h_wrap;
    logic                   v_wrap;
    logic [P_X_COORD_W-1:0] h_count;
    logic [P_Y_COORD_W-1:0] v_count;

    mod_counter #(.P_W(PRE_W), .P_MOD(P_CLK_DIV)) u_prescaler (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (!i_enable),
        .i_en    (i_enable),
        .o_count (pre_unused),
        .o_wrap  (tick)
    );

    mod_counter #(.P_W(P_X_COORD_W), .P_MOD(H_TOT)) u_hcounter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (!i_enable),
        .i_en    (tick),
        .o_count (h_count),
        .o_wrap  (h_wrap)
    );

    mod_counter #(.P_W(P_Y_COORD_W), .P_MOD(V_TOT)) u_vcounter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (!i_enable),
        .i_en    (h_wrap),
        .o_count (v_count),
        .o_wrap  (v_wrap)
    );

    logic [2:0] pins_raw;
    logic [2:0] pins_aligned;

    always_comb begin
        pins_raw[2] = !((h_count >= HS_START) && (h_count < HS_END));
        pins_raw[1] = !((v_count >= VS_START) && (v_count < VS_END));
        pins_raw[0] = (h_count >= H_ACT) || (v_count >= V_ACT);
    end

    // Delay raw timing by the buffer read latency so it meets i_pixel_on in the same cycle.
    generate
        if (P_RD_LAT > 0) begin : g_dly
            logic [3*P_RD_LAT-1:0] dly_q;
            logic [3*P_RD_LAT-1:0] dly_d;

            always_comb begin
                dly_d = {P_RD_LAT{PINS_IDLE}};
                if (i_enable) begin
                    dly_d      = dly_q << 3;
                    dly_d[2:0] = pins_raw;
                end
            end

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    dly_q <= {P_RD_LAT{PINS_IDLE}};
                end else begin
                    dly_q <= dly_d;
                end
            end

            assign pins_aligned = dly_q[3*P_RD_LAT-1 -: 3];
        end else begin : g_nodly
            assign pins_aligned = pins_raw;
        end
    endgenerate

    logic [2:0]         pins_q;
    logic [2:0]         pins_d;
    logic [P_RGB_W-1:0] rgb_q;
    logic [P_RGB_W-1:0] rgb_d;
    logic               frame_start_q;
    logic               frame_start_d;

    always_comb begin
        pins_d        = PINS_IDLE;
        rgb_d         = '0;
        frame_start_d = v_wrap && i_enable;
        if (i_enable) begin
            pins_d = pins_aligned;
            if (!pins_aligned[0]) begin
                rgb_d = i_pixel_on ? P_FG_COLOUR : P_BG_COLOUR;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pins_q        <= PINS_IDLE;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            pins_q        <= pins_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign o_hcounter    = h_count;
    assign o_vcounter    = v_count;
    assign o_hsync       = pins_q[2];
    assign o_vsync       = pins_q[1];
    assign o_blank       = pins_q[0];
    assign o_rgb         = rgb_q;
    assign o_vblank      = (v_count >= V_ACT);
    assign o_frame_start = frame_start_q;

endmodule
